// File: rtl/imem_port.sv
// imem_port: byte-addressed instruction memory with a multi-cycle fetch
// handshake (IDLE -> LATENCY x BUSY -> DONE) and a word-wide program port.
// Optional feature macro: IMEM_ALIGN_CHECK_EN -- when defined, a fetch whose
// address is not word aligned is reported as a fault and returns FAULT_INSN.
module imem_port #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DEPTH_BYTES = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] FAULT_INSN  = 32'h0000_0013
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic                  READ,
    output logic [31:0]           INSTRUCTION,
    output logic                  VALID,
    output logic                  FAULT,
    output logic                  BUSYWAIT,
    input  logic                  PROG_WE,
    input  logic [ADDR_WIDTH-1:0] PROG_ADDR,
    input  logic [31:0]           PROG_DATA
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH_BYTES - 4);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              cnt;
    logic [3:0]              cnt_next;
    logic [ADDR_WIDTH-1:0]   a;
    logic [ADDR_WIDTH-1:0]   a_next;
    logic                    load_en;
    logic [ADDR_WIDTH-1:0]   load_addr;
    logic                    load_fault;
    logic [31:0]             load_word;
    logic [IDX_W-1:0]        rd_idx0;
    logic [IDX_W-1:0]        rd_idx1;
    logic [IDX_W-1:0]        rd_idx2;
    logic [IDX_W-1:0]        rd_idx3;
    logic [ADDR_WIDTH-1:0]   prog_word_addr;
    logic                    prog_ok;
    logic [IDX_W-1:0]        wr_idx;

    logic [7:0] mem [DEPTH_BYTES];

    // Next-state logic: accept a fetch in IDLE, count down in BUSY, one DONE cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        a_next     = a;
        load_en    = 1'b0;
        case (state)
            IDLE: begin
                if (READ) begin
                    a_next = PC;
                    if (LATENCY == 0) begin
                        load_en    = 1'b1;
                        state_next = DONE;
                    end else begin
                        cnt_next   = CNT_INIT;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    load_en    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word assembly and fault detection; a zero-latency load uses PC directly since A is captured on the same edge.
    always_comb begin
        load_addr = (state == IDLE) ? PC : a;
        rd_idx0   = load_addr[IDX_W-1:0];
        rd_idx1   = rd_idx0 + IDX_W'(1);
        rd_idx2   = rd_idx0 + IDX_W'(2);
        rd_idx3   = rd_idx0 + IDX_W'(3);
        load_word = {mem[rd_idx3], mem[rd_idx2], mem[rd_idx1], mem[rd_idx0]};
`ifdef IMEM_ALIGN_CHECK_EN
        load_fault = (load_addr > LAST_WORD) || (load_addr[1:0] != 2'b00);
`else
        load_fault = (load_addr > LAST_WORD);
`endif
    end

    // Program-port decode: word-align the address and drop writes past the array.
    always_comb begin
        prog_word_addr = PROG_ADDR & ~ADDR_WIDTH'(3);
        prog_ok        = (prog_word_addr <= LAST_WORD);
        wr_idx         = prog_word_addr[IDX_W-1:0];
    end

    // FSM state, down-counter and captured fetch address.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= 4'd0;
            a     <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            a     <= a_next;
        end
    end

    // Registered fetch result; held until the next load.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            INSTRUCTION <= 32'h0;
            FAULT       <= 1'b0;
        end else if (load_en) begin
            INSTRUCTION <= load_fault ? FAULT_INSN : load_word;
            FAULT       <= load_fault;
        end
    end

    // Array write; contents survive reset and the load above reads the pre-write bytes.
    always_ff @(posedge CLK) begin
        if (PROG_WE && prog_ok) begin
            mem[wr_idx]                         <= PROG_DATA[7:0];
            mem[{wr_idx[IDX_W-1:2], 2'd1}]      <= PROG_DATA[15:8];
            mem[{wr_idx[IDX_W-1:2], 2'd2}]      <= PROG_DATA[23:16];
            mem[{wr_idx[IDX_W-1:2], 2'd3}]      <= PROG_DATA[31:24];
        end
    end

    assign VALID    = (state == DONE);
    assign BUSYWAIT = ~RESET & (((state == IDLE) & READ) | (state == BUSY));

endmodule

// File: tb/tb_imem_port.sv
// tb_imem_port: directed bench for imem_port with three instances
// (LATENCY = 2, 0 and 3) sharing clock, reset and the program bus.
module tb_imem_port;

    logic        CLK;
    logic        RESET;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic [31:0] pc          [3];
    logic        read        [3];
    logic [31:0] instruction [3];
    logic        valid       [3];
    logic        fault       [3];
    logic        busywait    [3];

    int errors = 0;
    int checks = 0;

    imem_port #(.LATENCY(2)) dut_l2 (
        .CLK(CLK), .RESET(RESET), .PC(pc[0]), .READ(read[0]),
        .INSTRUCTION(instruction[0]), .VALID(valid[0]), .FAULT(fault[0]),
        .BUSYWAIT(busywait[0]), .PROG_WE(prog_we), .PROG_ADDR(prog_addr),
        .PROG_DATA(prog_data)
    );

    imem_port #(.LATENCY(0)) dut_l0 (
        .CLK(CLK), .RESET(RESET), .PC(pc[1]), .READ(read[1]),
        .INSTRUCTION(instruction[1]), .VALID(valid[1]), .FAULT(fault[1]),
        .BUSYWAIT(busywait[1]), .PROG_WE(prog_we), .PROG_ADDR(prog_addr),
        .PROG_DATA(prog_data)
    );

    imem_port #(.LATENCY(3)) dut_l3 (
        .CLK(CLK), .RESET(RESET), .PC(pc[2]), .READ(read[2]),
        .INSTRUCTION(instruction[2]), .VALID(valid[2]), .FAULT(fault[2]),
        .BUSYWAIT(busywait[2]), .PROG_WE(prog_we), .PROG_ADDR(prog_addr),
        .PROG_DATA(prog_data)
    );

    // Free-running 10-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One program-port write, starting and ending on a falling edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLK);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(negedge CLK);
        prog_we   = 1'b0;
    endtask

    // Issue a fetch on instance u and wait (bounded) for VALID; cycles counts falling edges until VALID.
    task automatic runFetch(input int u, input logic [31:0] addr, input bit keep,
                            output int cycles, output int busy,
                            output logic [31:0] ins, output logic flt);
        pc[u]   = addr;
        read[u] = 1'b1;
        cycles  = 0;
        busy    = 0;
        #1;
        if (valid[u]) begin
            @(negedge CLK);
            #1;
            cycles = 1;
        end
        while (!valid[u] && cycles < 40) begin
            if (busywait[u]) busy++;
            @(negedge CLK);
            #1;
            cycles++;
        end
        ins = instruction[u];
        flt = fault[u];
        if (!keep) read[u] = 1'b0;
        checkOutput("fetch_timeout", 32'(cycles >= 40), 32'd0);
    endtask

    int          cyc;
    int          bsy;
    logic [31:0] ins;
    logic        flt;
    logic        saw_valid;

    // Directed sequence of test steps.
    initial begin
        RESET     = 1'b1;
        prog_we   = 1'b0;
        prog_addr = 32'h0;
        prog_data = 32'h0;
        for (int i = 0; i < 3; i++) begin
            pc[i]   = 32'h0;
            read[i] = 1'b0;
        end

        #1;
        checkOutput("reset_instruction", instruction[0], 32'h0);
        checkOutput("reset_valid", 32'(valid[0]), 32'd0);
        checkOutput("reset_fault", 32'(fault[0]), 32'd0);
        checkOutput("reset_busywait", 32'(busywait[0]), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        $display("[TB] basic fetch, LATENCY=2");
        applyStimulus(32'd0, 32'h0010_0093);
        applyStimulus(32'd4, 32'hDEAD_BEEF);
        runFetch(0, 32'd0, 1'b1, cyc, bsy, ins, flt);
        checkOutput("basic_instruction", ins, 32'h0010_0093);
        checkOutput("basic_fault", 32'(flt), 32'd0);
        checkOutput("basic_busy_cycles", 32'(bsy), 32'd3);
        checkOutput("basic_latency", 32'(cyc), 32'd3);
        checkOutput("basic_busywait_in_done", 32'(busywait[0]), 32'd0);
        runFetch(0, 32'd4, 1'b0, cyc, bsy, ins, flt);
        checkOutput("b2b_instruction", ins, 32'hDEAD_BEEF);
        checkOutput("b2b_spacing", 32'(cyc), 32'd4);
        @(negedge CLK);
        #1;
        checkOutput("valid_single_pulse", 32'(valid[0]), 32'd0);
        checkOutput("instruction_held", instruction[0], 32'hDEAD_BEEF);

        $display("[TB] zero latency");
        @(negedge CLK);
        runFetch(1, 32'd4, 1'b0, cyc, bsy, ins, flt);
        checkOutput("zl_instruction", ins, 32'hDEAD_BEEF);
        checkOutput("zl_latency", 32'(cyc), 32'd1);
        checkOutput("zl_busy_cycles", 32'(bsy), 32'd1);
        checkOutput("zl_fault", 32'(flt), 32'd0);

        $display("[TB] range fault and dropped out-of-range write");
        applyStimulus(32'd1020, 32'hCAFE_F00D);
        applyStimulus(32'd1024, 32'hBADB_AD00);
        @(negedge CLK);
        runFetch(0, 32'd1022, 1'b0, cyc, bsy, ins, flt);
        checkOutput("range_fault_flag", 32'(flt), 32'd1);
        checkOutput("range_fault_nop", ins, 32'h0000_0013);
        @(negedge CLK);
        runFetch(0, 32'd1020, 1'b0, cyc, bsy, ins, flt);
        checkOutput("last_word_fault", 32'(flt), 32'd0);
        checkOutput("last_word_data", ins, 32'hCAFE_F00D);
        @(negedge CLK);
        runFetch(0, 32'd0, 1'b0, cyc, bsy, ins, flt);
        checkOutput("oob_write_dropped", ins, 32'h0010_0093);

        $display("[TB] misaligned fetch");
        applyStimulus(32'd0, 32'h0302_0100);
        applyStimulus(32'd6, 32'h0706_0504);
        @(negedge CLK);
        runFetch(0, 32'd2, 1'b0, cyc, bsy, ins, flt);
`ifdef IMEM_ALIGN_CHECK_EN
        checkOutput("misalign_fault", 32'(flt), 32'd1);
        checkOutput("misalign_data", ins, 32'h0000_0013);
`else
        checkOutput("misalign_fault", 32'(flt), 32'd0);
        checkOutput("misalign_data", ins, 32'h0504_0302);
`endif

        $display("[TB] mid-fetch PC change and write on the load edge, LATENCY=3");
        applyStimulus(32'd0, 32'h1111_1111);
        applyStimulus(32'd8, 32'h2222_2222);
        @(negedge CLK);
        pc[2]   = 32'd0;
        read[2] = 1'b1;
        @(negedge CLK);
        pc[2]   = 32'd8;
        @(negedge CLK);
        @(negedge CLK);
        prog_we   = 1'b1;
        prog_addr = 32'd0;
        prog_data = 32'h3333_3333;
        @(negedge CLK);
        prog_we   = 1'b0;
        #1;
        checkOutput("midfetch_valid", 32'(valid[2]), 32'd1);
        checkOutput("midfetch_old_data", instruction[2], 32'h1111_1111);
        read[2] = 1'b0;
        @(negedge CLK);
        runFetch(2, 32'd0, 1'b0, cyc, bsy, ins, flt);
        checkOutput("midfetch_new_data", ins, 32'h3333_3333);
        checkOutput("l3_latency", 32'(cyc), 32'd4);

        $display("[TB] reset during BUSY");
        @(negedge CLK);
        pc[2]   = 32'd8;
        read[2] = 1'b1;
        @(negedge CLK);
        #1;
        checkOutput("busy_before_reset", 32'(busywait[2]), 32'd1);
        #1;
        RESET = 1'b1;
        #1;
        checkOutput("rst_instruction", instruction[2], 32'h0);
        checkOutput("rst_valid", 32'(valid[2]), 32'd0);
        checkOutput("rst_fault", 32'(fault[2]), 32'd0);
        checkOutput("rst_busywait", 32'(busywait[2]), 32'd0);
        read[2] = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (valid[2]) saw_valid = 1'b1;
        end
        checkOutput("no_valid_after_abort", 32'(saw_valid), 32'd0);
        runFetch(2, 32'd8, 1'b0, cyc, bsy, ins, flt);
        checkOutput("post_reset_data", ins, 32'h2222_2222);
        checkOutput("post_reset_fault", 32'(flt), 32'd0);
        checkOutput("post_reset_latency", 32'(cyc), 32'd4);

        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_port.md
# imem_port

Parametrised, byte-addressed instruction memory with a multi-cycle fetch handshake, used as the instruction-side memory for the pipelined RISC-V CPU. It replaces the zero-state combinational fetch model with a controller that holds a programmable array and captures the fetch address. It then waits a configurable number of cycles and returns a little-endian 32-bit word. While the fetch is outstanding it stalls the core through BUSYWAIT. A word-wide program port loads the array from the bench or a boot loader.

## Interface
- ADDR_WIDTH, 32: width of PC and PROG_ADDR.
- DEPTH_BYTES, 1024: array size in bytes. Must be a multiple of 4 and at least 4.
- LATENCY, 2: number of BUSY cycles per fetch. Valid range 0..15.
- FAULT_INSN, 32'h0000_0013: word returned on a faulting fetch (NOP).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PC  in  ADDR_WIDTH  fetch byte address; sampled only when a fetch is accepted.
- READ  in  1  fetch request; held high by the core until VALID.
- INSTRUCTION  out  32  fetched word, {mem[a+3],mem[a+2],mem[a+1],mem[a]}; registered.
- VALID  out  1  high for exactly the one DONE cycle; INSTRUCTION is valid in that cycle.
- FAULT  out  1  qualifies VALID; the fetch was out of range or misaligned.
- BUSYWAIT  out  1  combinational stall to the core.
- PROG_WE  in  1  program write enable.
- PROG_ADDR  in  ADDR_WIDTH  program byte address; bits [1:0] are ignored.
- PROG_DATA  in  32  word to write; byte 0 is written at the lowest address.

## Operation
- The FSM has three states, IDLE, BUSY and DONE, plus a 4-bit down-counter CNT and an address register A.
- IDLE:
  - If READ is high: capture A<=PC.
  - If LATENCY>0: set CNT<=LATENCY-1 and go to BUSY.
  - If LATENCY==0: perform the load (see below) and go to DONE.
- BUSY:
  - If CNT!=0: CNT<=CNT-1.
  - If CNT==0: perform the load and go to DONE.
- Load: INSTRUCTION<=word at A, or FAULT_INSN if faulting. FAULT<=fault condition.
- DONE: VALID=1. The next state is always IDLE. A READ seen in DONE belongs to the consumed fetch and is ignored.
- BUSYWAIT = ~RESET & ((state==IDLE & READ) | state==BUSY). It is 0 in DONE so the core advances PC at the end of that cycle.
- Fault condition: A > DEPTH_BYTES-4, i.e. any byte of the word lies out of range. The alignment check is added under the configuration macro.
- Changes on PC while in BUSY or DONE are ignored; A is authoritative.
- The program port is accepted in any state and writes 4 bytes at {PROG_ADDR[ADDR_WIDTH-1:2],2'b00}.
  - A program write to an out-of-range word is dropped.
  - A write and a load on the same edge to overlapping bytes: the load returns the pre-write contents (read-before-write).
- Reset:
  - State<=IDLE, CNT<=0, A<=0.
  - INSTRUCTION<=0, VALID<=0, FAULT<=0, BUSYWAIT=0.
  - Array contents are not cleared.
  - Reset during BUSY abandons the fetch; no VALID is produced.

## Timing
- A request accepted at edge k produces VALID and INSTRUCTION in the cycle after edge k+LATENCY.
- BUSYWAIT is high from the cycle READ rises through edge k+LATENCY.
- Back-to-back fetches: one word per LATENCY+2 cycles (IDLE, LATENCY×BUSY, DONE).
- LATENCY=0: IDLE→DONE in one edge; throughput is one word per 2 cycles.
- VALID is a single-cycle pulse. FAULT and INSTRUCTION hold their values until the next load or reset.
- CNT wrap-around cannot occur: the decrement happens only when CNT!=0.

## Configuration
- IMEM_ALIGN_CHECK_EN defined: a fetch with A[1:0]!=0 also sets FAULT and returns FAULT_INSN.
- IMEM_ALIGN_CHECK_EN undefined: an unaligned A is legal. The word is assembled from the bytes at A..A+3; only the range check applies.

## Test plan
- Basic fetch:
  - Stimulus: LATENCY=2; program word 0 = 32'h0010_0093; READ=1, PC=0.
  - Required: BUSYWAIT is high for 3 cycles; VALID pulses with INSTRUCTION=32'h0010_0093, FAULT=0.
  - Required: the next fetch starts 4 cycles after the first.
- Zero latency:
  - Stimulus: LATENCY=0; PC=4, word 32'hDEAD_BEEF.
  - Required: VALID in the cycle after acceptance; BUSYWAIT high for 1 cycle only.
- Range fault:
  - Stimulus: DEPTH_BYTES=1024; PC=1022, then PC=1020.
  - Required: first fetch gives FAULT=1 and INSTRUCTION=32'h0000_0013; second gives FAULT=0.
- Misalignment:
  - Stimulus: PC=2 with bytes 0..7 = 00..07.
  - With IMEM_ALIGN_CHECK_EN: FAULT=1 and the NOP is returned.
  - Without it: INSTRUCTION=32'h0504_0302.
- Mid-fetch changes:
  - Stimulus: LATENCY=3; PC changes 0→8 during BUSY; PROG_WE writes word 0 on the load edge.
  - Required: returns the old word-0 data; a following fetch returns the new data.
- Reset mid-fetch:
  - Stimulus: assert RESET during BUSY, asynchronously between edges.
  - Required: INSTRUCTION, VALID, FAULT and BUSYWAIT are 0 immediately; no VALID follows.
  - Required: after release, a new fetch completes normally with the array intact.
